// File: rtl/muldiv_seq_unit.sv
// Sequential signed multiply/divide unit: radix-2 Booth multiply and restoring divide,
// one step per clock, results loaded into HI/LO on completion.
module muldiv_seq_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {StIdle, StMult, StDiv, StFixup, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  // Shared datapath: acc holds the Booth accumulator or the division remainder, low holds
  // the multiplier or the dividend/quotient, opnd holds the multiplicand or |divisor|.
  // acc carries one guard bit so that adding/subtracting the most negative multiplicand
  // never loses the sign used by the arithmetic shift.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             qm1_q, qm1_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  // Per-step arithmetic for both algorithms and operand magnitudes for DIV setup.
  always_comb begin
    mcand_ext = {opnd_q[WIDTH-1], opnd_q};
    unique case ({low_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + mcand_ext;
      2'b10:   booth_sum = acc_q - mcand_ext;
      default: booth_sum = acc_q;
    endcase
    div_shift = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    a_abs     = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    b_abs     = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
  end

  // Next-state and datapath updates; every register holds unless its state updates it.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opnd_d    = opnd_q;
    qm1_d     = qm1_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    divzero_d = divzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          divzero_d = 1'b0;
          count_d   = '0;
          acc_d     = '0;
          qm1_d     = 1'b0;
          if (!op) begin
            state_d = StMult;
            low_d   = b_in;
            opnd_d  = a_in;
          end else begin
            // A zero divisor is detected on the first DIV cycle, giving a one-cycle
            // path to DONE with HI/LO untouched.
            state_d = StDiv;
            low_d   = a_abs;
            opnd_d  = b_abs;
            q_neg_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            r_neg_d = a_in[WIDTH-1];
          end
        end else begin
          state_d = StIdle;
        end
      end

      StMult: begin
        if (count_q == CW'(WIDTH)) begin
          state_d = StDone;
          hi_d    = acc_q[WIDTH-1:0];
          lo_d    = low_q;
        end else begin
          acc_d   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          low_d   = {booth_sum[0], low_q[WIDTH-1:1]};
          qm1_d   = low_q[0];
          count_d = count_q + 1'b1;
        end
      end

      StDiv: begin
        if (opnd_q == '0) begin
          state_d   = StDone;
          divzero_d = 1'b1;
        end else if (count_q == CW'(WIDTH)) begin
          state_d = StFixup;
        end else begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff;
            low_d = {low_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift;
            low_d = {low_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q + 1'b1;
        end
      end

      StFixup: begin
        state_d = StDone;
        lo_d    = q_neg_q ? (~low_q + 1'b1) : low_q;
        hi_d    = r_neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StMult) || (state_d == StDiv) || (state_d == StFixup);
    done_d = (state_d == StDone);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opnd_q    <= '0;
      qm1_q     <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opnd_q    <= opnd_d;
      qm1_q     <= qm1_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        divzero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks   = 0;
  int failures = 0;

  // Model copy of HI/LO, needed because divide-by-zero leaves them unchanged.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  muldiv_seq_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .divzero (divzero),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  // Reference: signed 64-bit multiply, truncating signed divide; b==0 keeps HI/LO.
  task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (!o) begin
      p    = sa * sb;
      m_hi = p[63:32];
      m_lo = p[31:0];
      lat  = 33;
    end else if (b == 32'd0) begin
      dz  = 1'b1;
      lat = 1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      m_lo = q[31:0];
      m_hi = r[31:0];
      lat  = 34;
    end
  endtask

  // Issue one operation, scramble inputs after acceptance, wait (bounded) for done.
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] h, output logic [31:0] l,
                       output logic dz, output logic busy0);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy0 = busy;
    a_in  = $urandom;
    b_in  = $urandom;
    op    = 1'($urandom_range(0, 1));
    lat   = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    h  = hi_out;
    l  = lo_out;
    dz = divzero;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, divzero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, divzero});
    end
    checks++;
    if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo got=%h/%h want=0/0", hi_out, lo_out);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult_basic();
    int lat, elat;
    logic [31:0] h, l;
    logic dz, b0, edz;
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, h, l, dz, b0);
    model(1'b0, 32'd7, 32'hFFFF_FFFD, elat, edz);
    checks++;
    if (b0 !== 1'b1) begin
      failures++;
      $display("FAIL mult_busy_after_accept got=%b want=1", b0);
    end
    checks++;
    if (lat != 33) begin
      failures++;
      $display("FAIL mult_latency got=%0d want=33", lat);
    end
    checks++;
    if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB || busy !== 1'b0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL mult_7x-3 got=%h/%h busy=%b dz=%b want=ffffffff/ffffffeb busy=0 dz=0",
               h, l, busy, dz);
    end
  endtask

  task automatic test_div_signs();
    int lat, elat;
    logic [31:0] h, l;
    logic dz, b0, edz;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, h, l, dz, b0);
    model(1'b1, 32'hFFFF_FFF9, 32'd2, elat, edz);
    checks++;
    if (lat != 34) begin
      failures++;
      $display("FAIL div_latency got=%0d want=34", lat);
    end
    checks++;
    if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL div_-7/2 got=%h/%h want=ffffffff/fffffffd", h, l);
    end
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, h, l, dz, b0);
    model(1'b1, 32'd7, 32'hFFFF_FFFE, elat, edz);
    checks++;
    if (l !== 32'hFFFF_FFFD || h !== 32'h0000_0001) begin
      failures++;
      $display("FAIL div_7/-2 got=%h/%h want=00000001/fffffffd", h, l);
    end
  endtask

  task automatic test_divzero();
    int lat, elat;
    logic [31:0] h, l;
    logic dz, b0, edz;
    // 0x451 / 0x20 = 0x22 rem 0x11 sets up known HI/LO.
    do_op(1'b1, 32'h451, 32'h20, lat, h, l, dz, b0);
    model(1'b1, 32'h451, 32'h20, elat, edz);
    checks++;
    if (h !== 32'h11 || l !== 32'h22) begin
      failures++;
      $display("FAIL divzero_setup got=%h/%h want=11/22", h, l);
    end
    do_op(1'b1, 32'd5, 32'd0, lat, h, l, dz, b0);
    model(1'b1, 32'd5, 32'd0, elat, edz);
    checks++;
    if (lat != 1 || dz !== 1'b1) begin
      failures++;
      $display("FAIL divzero_flag got lat=%0d dz=%b want lat=1 dz=1", lat, dz);
    end
    checks++;
    if (h !== 32'h11 || l !== 32'h22) begin
      failures++;
      $display("FAIL divzero_hold got=%h/%h want=11/22", h, l);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || divzero !== 1'b1) begin
      failures++;
      $display("FAIL divzero_sticky got done=%b dz=%b want done=0 dz=1", done, divzero);
    end
    do_op(1'b0, 32'd2, 32'd3, lat, h, l, dz, b0);
    model(1'b0, 32'd2, 32'd3, elat, edz);
    checks++;
    if (dz !== 1'b0 || l !== 32'd6) begin
      failures++;
      $display("FAIL divzero_clear got dz=%b lo=%h want dz=0 lo=6", dz, l);
    end
  endtask

  task automatic test_overflow();
    int lat, elat;
    logic [31:0] h, l;
    logic dz, b0, edz;
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, h, l, dz, b0);
    model(1'b0, 32'h8000_0000, 32'h8000_0000, elat, edz);
    checks++;
    if (h !== 32'h4000_0000 || l !== 32'd0) begin
      failures++;
      $display("FAIL mult_minxmin got=%h/%h want=40000000/0", h, l);
    end
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l, dz, b0);
    model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, elat, edz);
    checks++;
    if (l !== 32'h8000_0000 || h !== 32'd0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL div_min/-1 got=%h/%h dz=%b want=0/80000000 dz=0", h, l, dz);
    end
  endtask

  task automatic test_random();
    int lat, elat;
    logic [31:0] h, l, a, b;
    logic dz, b0, edz, o;
    for (int i = 0; i < 40; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(16, 31);
      if ($urandom_range(0, 3) == 0) b = 32'($signed(b) >>> $urandom_range(16, 31));
      do_op(o, a, b, lat, h, l, dz, b0);
      model(o, a, b, elat, edz);
      checks++;
      if (h !== m_hi || l !== m_lo || dz !== edz || lat != elat) begin
        failures++;
        $display("FAIL random_%0d op=%b a=%h b=%h got=%h/%h dz=%b lat=%0d want=%h/%h dz=%b lat=%0d",
                 i, o, a, b, h, l, dz, lat, m_hi, m_lo, edz, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, elat;
    logic [31:0] h, l;
    logic dz, b0, edz;
    do_op(1'b0, 32'd12345, 32'hFFFF_FF00, lat, h, l, dz, b0);
    model(1'b0, 32'd12345, 32'hFFFF_FF00, elat, edz);
    // The next start is driven during the DONE cycle, so busy follows done directly.
    do_op(1'b1, 32'd1000, 32'd7, lat, h, l, dz, b0);
    model(1'b1, 32'd1000, 32'd7, elat, edz);
    checks++;
    if (b0 !== 1'b1 || lat != 34) begin
      failures++;
      $display("FAIL back_to_back got busy=%b lat=%0d want busy=1 lat=34", b0, lat);
    end
    checks++;
    if (h !== m_hi || l !== m_lo) begin
      failures++;
      $display("FAIL back_to_back_result got=%h/%h want=%h/%h", h, l, m_hi, m_lo);
    end
  endtask

  task automatic test_busy_ignore();
    int pulses, first;
    logic [31:0] h, l;
    pulses = 0;
    first  = -1;
    h      = '0;
    l      = '0;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a_in  = 32'd100;
    b_in  = 32'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 10) begin
        start = 1'b1;
        op    = 1'b1;
        a_in  = 32'd9;
        b_in  = 32'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = n;
          h     = hi_out;
          l     = lo_out;
        end
      end
    end
    m_hi = 32'd0;
    m_lo = 32'd10000;
    checks++;
    if (pulses != 1 || first != 33) begin
      failures++;
      $display("FAIL busy_ignore_done got pulses=%0d at=%0d want pulses=1 at=33", pulses, first);
    end
    checks++;
    if (h !== 32'd0 || l !== 32'h2710) begin
      failures++;
      $display("FAIL busy_ignore_result got=%h/%h want=0/2710", h, l);
    end
  endtask

  task automatic test_reset_midop();
    int pulses;
    pulses = 0;
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a_in  = 32'd1000;
    b_in  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #4;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, divzero} !== 3'b000 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_midop got flags=%b hi=%h lo=%h want 000/0/0",
               {busy, done, divzero}, hi_out, lo_out);
    end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_no_done got active_cycles=%0d want=0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_div_signs();
    test_divzero();
    test_overflow();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
